mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 154 +++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bundle between a multicycle controller (master) and
//   the mem_responder memory model (slave).
//   mem_read, mem_write : request strobes from the controller
//   addr                : 16-bit word address
//   wdata               : 32-bit write data
//   rdata               : 32-bit registered read data
//   ready               : one-cycle completion pulse
//   busy                : a request is in progress
//   err                 : error flag, meaningful only while ready is high
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory model with a fixed response latency, answering a
//   multicycle controller. A request is accepted in IDLE, the request is
//   latched, and a single ready pulse is produced LATENCY cycles after the
//   acceptance edge. Out-of-range addresses and read+write conflicts report
//   err with ready and never touch storage.
//   Parameters: DEPTH   - number of 32-bit words stored
//               LATENCY - acceptance-to-ready cycles, 1..15
//   Ports:      clk     - clock, rising edge
//               reset   - synchronous, active-high; aborts a request in flight
//               bus     - mem_responder_if slave modport
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        op_rd;
    logic        op_wr;
    logic [15:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        ready_r;
    logic        busy_r;
    logic        err_r;
    logic [31:0] rdata_r;

    // Contents survive reset; zero at time zero.
    logic [31:0] storage [DEPTH] = '{default: 32'd0};

    // Operation the response is computed from: in IDLE (only relevant when
    // LATENCY==1) the live request, otherwise the latched copy.
    logic        src_rd;
    logic        src_wr;
    logic [15:0] src_addr;
    logic        in_range;
    logic        conflict;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_seen;
    logic        enter_resp;

    always_comb begin
        src_rd   = op_rd;
        src_wr   = op_wr;
        src_addr = lat_addr;
        if (state == IDLE) begin
            src_rd   = bus.mem_read;
            src_wr   = bus.mem_write;
            src_addr = bus.addr;
        end
        in_range = ({16'd0, src_addr} < DEPTH_U);
        conflict = src_rd && src_wr;
        rsp_err  = conflict || !in_range;

        // Conflicts and writes leave rdata alone; only a read replaces it.
        rsp_rdata = rdata_r;
        if (src_rd && !conflict) begin
            rsp_rdata = in_range ? storage[src_addr[AW-1:0]] : 32'd0;
        end

        req_seen   = bus.mem_read || bus.mem_write;
        enter_resp = ((state == IDLE) && req_seen && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    if (req_seen) begin
                        op_rd     <= bus.mem_read;
                        op_wr     <= bus.mem_write;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        busy_r    <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Always one cycle; any request seen here is dropped.
                    state   <= IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase

            // Response outputs are registered on the edge that enters RESP.
            if (enter_resp) begin
                ready_r <= 1'b1;
                err_r   <= rsp_err;
                rdata_r <= rsp_rdata;
            end
        end
    end

    // Write commits on the edge that ends the ready cycle, unless reset
    // arrives on that same edge.
    always_ff @(posedge clk) begin
        if (!reset && (state == RESP) && op_wr && !op_rd && in_range) begin
            storage[lat_addr[AW-1:0]] <= lat_wdata;
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Three responders (LATENCY 2, 1 and 4, DEPTH 256) driven by directed
//   steps; expected responses come from a small memory model and are
//   queued on drive and popped when ready is seen.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [15:0] ad [3];
    logic [31:0] wd [3];
    logic [2:0]  rdy_o;
    logic [2:0]  busy_o;
    logic [2:0]  err_o;
    logic [31:0] rdata_o [3];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : gd
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        mem_responder_if bus ();
        assign bus.mem_read  = rd[g];
        assign bus.mem_write = wr[g];
        assign bus.addr      = ad[g];
        assign bus.wdata     = wd[g];
        assign rdy_o[g]      = bus.ready;
        assign busy_o[g]     = bus.busy;
        assign err_o[g]      = bus.err;
        assign rdata_o[g]    = bus.rdata;
        mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [3][256];
    logic [31:0] mrd [3];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // One request through the scoreboard: latency, busy/err while waiting,
    // then err and rdata in the ready cycle.
    task automatic req(input int d, input bit r, input bit w,
                       input logic [15:0] a, input logic [31:0] dat);
        exp_t e;
        int   got;
        if (r && w) begin
            e.err = 1'b1;
        end else if (a >= 16'd256) begin
            e.err = 1'b1;
            if (r) mrd[d] = 32'd0;
        end else if (r) begin
            e.err  = 1'b0;
            mrd[d] = mdl[d][a[7:0]];
        end else begin
            e.err = 1'b0;
            mdl[d][a[7:0]] = dat;
        end
        e.rdata = mrd[d];
        sb.push_back(e);

        @(negedge clk);
        chk("idle_busy", {31'd0, busy_o[d]}, 32'd0);
        rd[d] = r;
        wr[d] = w;
        ad[d] = a;
        wd[d] = dat;
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy_o[d]) begin
                got = k;
                break;
            end
            chk("wait_busy", {31'd0, busy_o[d]}, 32'd1);
            chk("err_without_ready", {31'd0, err_o[d]}, 32'd0);
        end
        chk("latency", got, lat_of(d));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_err", {31'd0, err_o[d]}, {31'd0, e.err});
            chk("resp_rdata", rdata_o[d], e.rdata);
            chk("resp_busy", {31'd0, busy_o[d]}, 32'd1);
        end
    endtask

    initial begin
        int pulses;
        int got;
        rst = 3'b111;
        rd  = 3'b000;
        wr  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ad[i]  = 16'd0;
            wd[i]  = 32'd0;
            mrd[i] = 32'd0;
            for (int j = 0; j < 256; j++) mdl[i][j] = 32'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {31'd0, rdy_o[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy_o[i]}, 32'd0);
            chk("rst_err", {31'd0, err_o[i]}, 32'd0);
            chk("rst_rdata", rdata_o[i], 32'd0);
        end
        rst = 3'b000;

        // LATENCY=2: write then read back
        req(0, 0, 1, 16'h0005, 32'hDEADBEEF);
        req(0, 1, 0, 16'h0005, 32'h0);
        // Out of range, with addr 0 protected from aliasing
        req(0, 0, 1, 16'h0000, 32'h11112222);
        req(0, 1, 0, 16'h0100, 32'h0);
        req(0, 0, 1, 16'h0100, 32'h00000001);
        req(0, 1, 0, 16'h0000, 32'h0);
        // Read+write conflict: err, rdata held, no storage access
        req(0, 1, 1, 16'h0003, 32'h12345678);
        req(0, 1, 0, 16'h0003, 32'h0);
        req(0, 1, 0, 16'h0005, 32'h0);

        // LATENCY=1: back-to-back request during RESP is not accepted
        req(1, 0, 1, 16'h0005, 32'h00000055);
        req(1, 0, 1, 16'h0009, 32'h00000099);
        @(negedge clk);
        chk("l1_busy_T", {31'd0, busy_o[1]}, 32'd0);
        rd[1] = 1'b1;
        ad[1] = 16'h0005;
        @(negedge clk);
        chk("l1_ready_T1", {31'd0, rdy_o[1]}, 32'd1);
        chk("l1_busy_T1", {31'd0, busy_o[1]}, 32'd1);
        chk("l1_rdata_T1", rdata_o[1], 32'h00000055);
        ad[1] = 16'h0009;
        @(negedge clk);
        chk("l1_ready_T2", {31'd0, rdy_o[1]}, 32'd0);
        chk("l1_busy_T2", {31'd0, busy_o[1]}, 32'd0);
        @(posedge clk);
        #1;
        rd[1] = 1'b0;
        @(negedge clk);
        chk("l1_ready_T3", {31'd0, rdy_o[1]}, 32'd1);
        chk("l1_rdata_T3", rdata_o[1], 32'h00000099);
        mrd[1] = 32'h00000099;

        // Reset wins over a simultaneous request
        @(negedge clk);
        rst[1] = 1'b1;
        rd[1]  = 1'b1;
        ad[1]  = 16'h0005;
        @(negedge clk);
        rst[1] = 1'b0;
        rd[1]  = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdy_o[1] || busy_o[1]) pulses++;
        end
        chk("l1_rst_drop", pulses, 0);
        chk("l1_rst_rdata", rdata_o[1], 32'd0);
        mrd[1] = 32'd0;
        req(1, 1, 0, 16'h0009, 32'h0);

        // LATENCY=4: reset two cycles after acceptance aborts the write
        @(negedge clk);
        wr[2] = 1'b1;
        ad[2] = 16'h0007;
        wd[2] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        wr[2] = 1'b0;
        @(negedge clk);
        chk("l4_busy_c1", {31'd0, busy_o[2]}, 32'd1);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("l4_busy_after_rst", {31'd0, busy_o[2]}, 32'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy_o[2]) pulses++;
        end
        chk("l4_no_ready", pulses, 0);
        mrd[2] = 32'd0;
        req(2, 1, 0, 16'h0007, 32'h0);

        // LATENCY=4: inputs churn during WAIT; latched write must win
        @(negedge clk);
        chk("l4_idle_busy", {31'd0, busy_o[2]}, 32'd0);
        wr[2] = 1'b1;
        ad[2] = 16'h0002;
        wd[2] = 32'h0000CAFE;
        mdl[2][2] = 32'h0000CAFE;
        @(posedge clk);
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rdy_o[2]) begin
                got = k;
                rd[2] = 1'b0;
                wr[2] = 1'b0;
                break;
            end
            ad[2] = 16'h0010 + 16'(k);
            wd[2] = $urandom;
            wr[2] = 1'b1;
            rd[2] = k[0];
        end
        chk("l4_churn_latency", got, 4);
        chk("l4_churn_err", {31'd0, err_o[2]}, 32'd0);
        req(2, 1, 0, 16'h0002, 32'h0);
        req(2, 1, 0, 16'h0011, 32'h0);
        req(2, 1, 0, 16'h0012, 32'h0);
        req(2, 1, 0, 16'h0013, 32'h0);
        req(2, 1, 0, 16'h0007, 32'h0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
